// File: rtl/p405s_srm_pkg.sv
// Shared definitions for the SRM rotate/shift datapath: widths and op encodings.
package p405s_srm_pkg;

    localparam int unsigned SrmWidth   = 32;
    localparam int unsigned SrmOpWidth = 3;

    localparam logic [SrmOpWidth-1:0] OpRlwnm  = 3'b000;  // rlwinm / rlwnm
    localparam logic [SrmOpWidth-1:0] OpRlwimi = 3'b001;
    localparam logic [SrmOpWidth-1:0] OpSlw    = 3'b010;
    localparam logic [SrmOpWidth-1:0] OpSrw    = 3'b011;
    localparam logic [SrmOpWidth-1:0] OpSraw   = 3'b100;  // sraw / srawi

endpackage

// File: rtl/p405s_srm_mask_gen.sv
// Combinational MB..ME mask with wrap-around. Big-endian numbering: mask bit i
// lives at packed position 31-i, so "i >= b" is all-ones shifted right by b.
module p405s_srm_mask_gen
    import p405s_srm_pkg::*;
(
    input  logic [4:0]          maskBegin,
    input  logic [4:0]          maskEnd,
    output logic [SrmWidth-1:0] mask_c
);

    logic [SrmWidth-1:0] fromBegin;
    logic [SrmWidth-1:0] toEnd;

    // Non-wrapping masks are the overlap of the two ranges; wrapping masks are their union.
    always_comb begin
        fromBegin = {SrmWidth{1'b1}} >> maskBegin;
        toEnd     = {SrmWidth{1'b1}} << (5'd31 - maskEnd);
        mask_c    = (maskBegin <= maskEnd) ? (fromBegin & toEnd) : (fromBegin | toEnd);
    end

endmodule

// File: rtl/p405s_srm_mask_merge.sv
// SRM mask/merge stage: mask generation, insert/sign-fill merge and XER[CA] in
// S1, CR0 compare in S2. Results feed the writeback mux two cycles after capture.
module p405s_srm_mask_merge
    import p405s_srm_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          CR0_EN = 1'b1
)
(
    input  logic             CB,
    input  logic             syncReset,
    input  logic             exeValid,
    input  logic             exeHold,
    input  logic             exeFlush,
    input  logic [2:0]       srmOp,
    input  logic [4:0]       srmMb,
    input  logic [4:0]       srmMe,
    input  logic [5:0]       srmShAmt,
    input  logic [WIDTH-1:0] blrIn,
    input  logic [WIDTH-1:0] rsIn,
    input  logic [WIDTH-1:0] raIn,
    input  logic             srmRc,
    input  logic             xerSo,
    output logic             wbValid,
    output logic [WIDTH-1:0] wbResult,
    output logic             wbCa,
    output logic             wbCaUpd,
    output logic [3:0]       wbCr0,
    output logic             wbCr0Upd
);

    if (WIDTH != SrmWidth) begin : gWidthCheck
        $error("p405s_srm_mask_merge: WIDTH must be 32");
    end

    logic             shBig;
    logic [4:0]       shLow;
    logic [4:0]       maskBegin;
    logic [4:0]       maskEnd;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sraMask;
    logic [WIDTH-1:0] signFill;
    logic [WIDTH-1:0] nextResult;
    logic             nextCa;
    logic             nextCaUpd;

    logic             s1Valid;
    logic [WIDTH-1:0] s1Result;
    logic             s1Ca;
    logic             s1CaUpd;
    logic             s1Rc;

    assign shBig = srmShAmt[5];
    assign shLow = srmShAmt[4:0];

    // Mask bounds per op; shifts are expressed as masks over the pre-rotated word.
    always_comb begin
        maskBegin = srmMb;
        maskEnd   = srmMe;
        case (srmOp)
            OpSlw: begin
                maskBegin = 5'd0;
                maskEnd   = 5'd31 - shLow;
            end
            OpSrw, OpSraw: begin
                maskBegin = shLow;
                maskEnd   = 5'd31;
            end
            default: ;
        endcase
    end

    p405s_srm_mask_gen uMaskGen (
        .maskBegin (maskBegin),
        .maskEnd   (maskEnd),
        .mask_c    (mask)
    );

    // Merge rotated data with insert or sign-fill data and derive the carry.
    always_comb begin
        nextResult = '0;
        nextCa     = 1'b0;
        nextCaUpd  = 1'b0;
        signFill   = {WIDTH{rsIn[WIDTH-1]}};
        sraMask    = shBig ? '0 : mask;
        case (srmOp)
            OpRlwnm:  nextResult = blrIn & mask;
            OpRlwimi: nextResult = (blrIn & mask) | (raIn & ~mask);
            OpSlw,
            OpSrw:    nextResult = shBig ? '0 : (blrIn & mask);
            OpSraw: begin
                nextResult = (blrIn & sraMask) | (signFill & ~sraMask);
                nextCa     = rsIn[WIDTH-1] & (shBig ? (|rsIn) : (|(blrIn & ~sraMask)));
                nextCaUpd  = 1'b1;
            end
            default: ;
        endcase
    end

    // S1: capture a new op; bubbles clear only the valid bit.
    always_ff @(posedge CB) begin
        if (syncReset) begin
            s1Valid  <= 1'b0;
            s1Result <= '0;
            s1Ca     <= 1'b0;
            s1CaUpd  <= 1'b0;
            s1Rc     <= 1'b0;
        end else if (exeFlush) begin
            s1Valid <= 1'b0;
        end else if (!exeHold) begin
            s1Valid <= exeValid;
            if (exeValid) begin
                s1Result <= nextResult;
                s1Ca     <= nextCa;
                s1CaUpd  <= nextCaUpd;
                s1Rc     <= srmRc;
            end
        end
    end

    // S2: writeback result and carry; strobes are qualified by the incoming valid.
    always_ff @(posedge CB) begin
        if (syncReset) begin
            wbValid  <= 1'b0;
            wbResult <= '0;
            wbCa     <= 1'b0;
            wbCaUpd  <= 1'b0;
        end else if (exeFlush) begin
            wbValid <= 1'b0;
            wbCaUpd <= 1'b0;
        end else if (!exeHold) begin
            wbValid <= s1Valid;
            wbCaUpd <= s1Valid & s1CaUpd;
            if (s1Valid) begin
                wbResult <= s1Result;
                if (s1CaUpd) begin
                    wbCa <= s1Ca;
                end
            end
        end
    end

    if (CR0_EN) begin : gCr0
        logic       cr0Lt;
        logic       cr0Eq;
        logic [3:0] cr0Next;

        // Signed compare of the S1 result against zero; SO taken on the transfer edge.
        always_comb begin
            cr0Lt   = s1Result[WIDTH-1];
            cr0Eq   = (s1Result == '0);
            cr0Next = {cr0Lt, ~cr0Lt & ~cr0Eq, cr0Eq, xerSo};
        end

        // S2: CR0 field, written only by a valid record-form op.
        always_ff @(posedge CB) begin
            if (syncReset) begin
                wbCr0    <= 4'b0000;
                wbCr0Upd <= 1'b0;
            end else if (exeFlush) begin
                wbCr0Upd <= 1'b0;
            end else if (!exeHold) begin
                wbCr0Upd <= s1Valid & s1Rc;
                if (s1Valid && s1Rc) begin
                    wbCr0 <= cr0Next;
                end
            end
        end
    end else begin : gNoCr0
        assign wbCr0    = 4'b0000;
        assign wbCr0Upd = 1'b0;
    end

endmodule

// File: tb/tb_p405s_srm_mask_merge.sv
// Bench for the SRM mask/merge stage: directed vectors with literal expectations
// plus a per-cycle comparison against a bit-level behavioural model.
module tb_p405s_srm_mask_merge;

    localparam logic [2:0] OP_RLW  = 3'b000;
    localparam logic [2:0] OP_IMI  = 3'b001;
    localparam logic [2:0] OP_SLW  = 3'b010;
    localparam logic [2:0] OP_SRW  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic        CB = 1'b0;
    logic        syncReset = 1'b1;
    logic        exeValid = 1'b0;
    logic        exeHold = 1'b0;
    logic        exeFlush = 1'b0;
    logic [2:0]  srmOp = 3'b000;
    logic [4:0]  srmMb = 5'd0;
    logic [4:0]  srmMe = 5'd0;
    logic [5:0]  srmShAmt = 6'd0;
    logic [31:0] blrIn = 32'h0;
    logic [31:0] rsIn = 32'h0;
    logic [31:0] raIn = 32'h0;
    logic        srmRc = 1'b0;
    logic        xerSo = 1'b0;
    logic        wbValid;
    logic [31:0] wbResult;
    logic        wbCa;
    logic        wbCaUpd;
    logic [3:0]  wbCr0;
    logic        wbCr0Upd;

    int nChecks = 0;
    int nPass   = 0;
    logic chkEn = 1'b0;

    p405s_srm_mask_merge dut (
        .CB        (CB),
        .syncReset (syncReset),
        .exeValid  (exeValid),
        .exeHold   (exeHold),
        .exeFlush  (exeFlush),
        .srmOp     (srmOp),
        .srmMb     (srmMb),
        .srmMe     (srmMe),
        .srmShAmt  (srmShAmt),
        .blrIn     (blrIn),
        .rsIn      (rsIn),
        .raIn      (raIn),
        .srmRc     (srmRc),
        .xerSo     (xerSo),
        .wbValid   (wbValid),
        .wbResult  (wbResult),
        .wbCa      (wbCa),
        .wbCaUpd   (wbCaUpd),
        .wbCr0     (wbCr0),
        .wbCr0Upd  (wbCr0Upd)
    );

    always #5 CB = ~CB;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Big-endian mask bit i from the MB..ME rule.
    function automatic logic [31:0] maskOf(input int b, input int e);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            if (b <= e) m[31-i] = (i >= b) && (i <= e);
            else        m[31-i] = (i >= b) || (i <= e);
        end
        return m;
    endfunction

    task automatic refOp(input logic [2:0] op, input int mb, input int me, input int n,
                         input logic [31:0] blr, input logic [31:0] rs, input logic [31:0] ra,
                         output logic [31:0] res, output logic ca, output logic caUpd);
        logic [31:0] m;
        res = 32'h0; ca = 1'b0; caUpd = 1'b0;
        case (op)
            OP_RLW: res = blr & maskOf(mb, me);
            OP_IMI: begin m = maskOf(mb, me); res = (blr & m) | (ra & ~m); end
            OP_SLW: res = (n < 32) ? (blr & maskOf(0, 31 - n)) : 32'h0;
            OP_SRW: res = (n < 32) ? (blr & maskOf(n, 31)) : 32'h0;
            OP_SRA: begin
                m = (n < 32) ? maskOf(n, 31) : 32'h0;
                res = (blr & m) | ((rs[31] ? 32'hFFFF_FFFF : 32'h0) & ~m);
                if (n >= 32) ca = rs[31] && (rs != 32'h0);
                else         ca = rs[31] && ((blr & ~m) != 32'h0);
                caUpd = 1'b1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] cr0Of(input logic [31:0] r, input logic so);
        return {$signed(r) < 0, $signed(r) > 0, r == 32'h0, so};
    endfunction

    // Behavioural model: one in-flight slot plus the visible writeback state.
    logic        m1Valid = 1'b0, m1Ca = 1'b0, m1CaUpd = 1'b0, m1Rc = 1'b0;
    logic [31:0] m1Res = 32'h0;
    logic        mValid = 1'b0, mCa = 1'b0, mCaUpd = 1'b0, mCr0Upd = 1'b0;
    logic [31:0] mRes = 32'h0;
    logic [3:0]  mCr0 = 4'h0;

    always @(posedge CB) begin : modelProc
        logic [31:0] r;
        logic        c, cu;
        if (syncReset) begin
            m1Valid = 0; m1Ca = 0; m1CaUpd = 0; m1Rc = 0; m1Res = 0;
            mValid = 0; mCa = 0; mCaUpd = 0; mCr0Upd = 0; mRes = 0; mCr0 = 0;
        end else if (exeFlush) begin
            m1Valid = 0; mValid = 0; mCaUpd = 0; mCr0Upd = 0;
        end else if (!exeHold) begin
            mValid  = m1Valid;
            mCaUpd  = m1Valid && m1CaUpd;
            mCr0Upd = m1Valid && m1Rc;
            if (m1Valid) begin
                mRes = m1Res;
                if (m1CaUpd) mCa = m1Ca;
                if (m1Rc) mCr0 = cr0Of(m1Res, xerSo);
            end
            m1Valid = exeValid;
            if (exeValid) begin
                refOp(srmOp, int'(srmMb), int'(srmMe), int'(srmShAmt), blrIn, rsIn, raIn, r, c, cu);
                m1Res = r; m1Ca = c; m1CaUpd = cu; m1Rc = srmRc;
            end
        end
        chkEn <= 1'b1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CB) begin
        if (chkEn) begin
            chk("cmp wbValid",  32'(wbValid),  32'(mValid));
            chk("cmp wbResult", wbResult,      mRes);
            chk("cmp wbCa",     32'(wbCa),     32'(mCa));
            chk("cmp wbCaUpd",  32'(wbCaUpd),  32'(mCaUpd));
            chk("cmp wbCr0",    32'(wbCr0),    32'(mCr0));
            chk("cmp wbCr0Upd", 32'(wbCr0Upd), 32'(mCr0Upd));
        end
    end

    // Collect each distinct op leaving the pipe (edges without hold) during the hold test.
    logic        collect = 1'b0;
    logic        holdAtEdge = 1'b0;
    logic [31:0] outQ[$];
    always @(posedge CB) holdAtEdge <= exeHold;
    always @(negedge CB) begin
        if (collect && wbValid && !holdAtEdge) outQ.push_back(wbResult);
    end

    task automatic drive(input logic [2:0] op, input logic [4:0] mb, input logic [4:0] me,
                         input logic [5:0] sh, input logic [31:0] blr, input logic [31:0] rs,
                         input logic [31:0] ra, input logic rc, input logic so);
        srmOp = op; srmMb = mb; srmMe = me; srmShAmt = sh;
        blrIn = blr; rsIn = rs; raIn = ra; srmRc = rc; xerSo = so;
        exeValid = 1'b1;
    endtask

    task automatic runOne(input string name, input logic [2:0] op, input logic [4:0] mb,
                          input logic [4:0] me, input logic [5:0] sh, input logic [31:0] blr,
                          input logic [31:0] rs, input logic [31:0] ra, input logic rc,
                          input logic so, input logic [31:0] expRes, input logic expCaUpd,
                          input logic expCa);
        @(negedge CB);
        drive(op, mb, me, sh, blr, rs, ra, rc, so);
        @(negedge CB);
        exeValid = 1'b0;
        @(negedge CB);
        chk({name, " valid"},  32'(wbValid), 32'd1);
        chk({name, " result"}, wbResult, expRes);
        chk({name, " caUpd"},  32'(wbCaUpd), 32'(expCaUpd));
        if (expCaUpd) chk({name, " ca"}, 32'(wbCa), 32'(expCa));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
        $fatal(1);
    end

    initial begin
        @(negedge CB);
        @(negedge CB);
        chk("reset wbValid",  32'(wbValid), 32'd0);
        chk("reset wbResult", wbResult, 32'h0);
        chk("reset wbCr0",    32'(wbCr0), 32'd0);
        syncReset = 1'b0;

        // Directed ops: name, op, mb, me, n, blr, rs, ra, rc, so, result, caUpd, ca.
        runOne("rlwinm low byte", OP_RLW, 5'd24, 5'd31, 6'd0, 32'h12345678, 32'h0, 32'h0, 0, 0, 32'h00000078, 0, 0);
        runOne("rlwinm wrap",     OP_RLW, 5'd28, 5'd3,  6'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 32'hF000000F, 0, 0);
        runOne("rlwimi wrap ra0", OP_IMI, 5'd28, 5'd3,  6'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 32'hF000000F, 0, 0);
        runOne("rlwimi insert",   OP_IMI, 5'd28, 5'd3,  6'd0, 32'hFFFFFFFF, 32'h0, 32'h12345678, 0, 0, 32'hF234567F, 0, 0);
        runOne("rlwinm mb=me+1",  OP_RLW, 5'd5,  5'd4,  6'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 0, 32'hA5A5A5A5, 0, 0);
        runOne("sraw n4",         OP_SRA, 5'd0,  5'd0,  6'd4, 32'h08000001, 32'h80000010, 32'h0, 0, 0, 32'hF8000001, 1, 0);
        runOne("sraw n5",         OP_SRA, 5'd0,  5'd0,  6'd5, 32'h84000000, 32'h80000010, 32'h0, 0, 0, 32'hFC000000, 1, 1);
        runOne("sraw n0",         OP_SRA, 5'd0,  5'd0,  6'd0, 32'h80000001, 32'h80000001, 32'h0, 0, 0, 32'h80000001, 1, 0);
        runOne("slw n4",          OP_SLW, 5'd0,  5'd0,  6'd4, 32'h23456781, 32'h12345678, 32'h0, 0, 0, 32'h23456780, 0, 0);
        runOne("srw n8",          OP_SRW, 5'd0,  5'd0,  6'd8, 32'h78123456, 32'h12345678, 32'h0, 0, 0, 32'h00123456, 0, 0);
        runOne("slw n32",         OP_SLW, 5'd0,  5'd0,  6'd32, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, 32'h0, 0, 0);
        runOne("srw n40",         OP_SRW, 5'd0,  5'd0,  6'd40, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, 32'h0, 0, 0);
        runOne("sraw n33",        OP_SRA, 5'd0,  5'd0,  6'd33, 32'h80000000, 32'h80000000, 32'h0, 0, 0, 32'hFFFFFFFF, 1, 1);
        runOne("reserved op",     OP_RSV, 5'd0,  5'd31, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0);
        chk("reserved keeps ca", 32'(wbCa), 32'd1);

        // CR0 record forms.
        runOne("cr0 zero", OP_RLW, 5'd0, 5'd31, 6'd0, 32'h00000000, 32'h0, 32'h0, 1, 1, 32'h00000000, 0, 0);
        chk("cr0 zero upd", 32'(wbCr0Upd), 32'd1);
        chk("cr0 zero val", 32'(wbCr0), 32'b0011);
        runOne("cr0 neg", OP_RLW, 5'd0, 5'd31, 6'd0, 32'h80000000, 32'h0, 32'h0, 1, 0, 32'h80000000, 0, 0);
        chk("cr0 neg upd", 32'(wbCr0Upd), 32'd1);
        chk("cr0 neg val", 32'(wbCr0), 32'b1000);
        runOne("cr0 no rc", OP_RLW, 5'd0, 5'd31, 6'd0, 32'h00000005, 32'h0, 32'h0, 0, 1, 32'h00000005, 0, 0);
        chk("cr0 no rc upd", 32'(wbCr0Upd), 32'd0);
        chk("cr0 no rc hold", 32'(wbCr0), 32'b1000);

        // Back-to-back ops with a 3-cycle hold.
        @(negedge CB);
        collect = 1'b1;
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'h11111111, 32'h0, 32'h0, 0, 0);
        @(negedge CB);
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'h22222222, 32'h0, 32'h0, 0, 0);
        @(negedge CB);
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'h33333333, 32'h0, 32'h0, 0, 0);
        exeHold = 1'b1;
        @(negedge CB);
        chk("hold frozen valid", 32'(wbValid), 32'd1);
        chk("hold frozen result", wbResult, 32'h11111111);
        @(negedge CB);
        chk("hold still frozen", wbResult, 32'h11111111);
        @(negedge CB);
        exeHold = 1'b0;
        @(negedge CB);
        exeValid = 1'b0;
        @(negedge CB);
        @(negedge CB);
        collect = 1'b0;
        chk("hold op count", 32'(outQ.size()), 32'd3);
        if (outQ.size() == 3) begin
            chk("hold op0", outQ[0], 32'h11111111);
            chk("hold op1", outQ[1], 32'h22222222);
            chk("hold op2", outQ[2], 32'h33333333);
        end

        // Flush with both stages valid, also asserting hold and a same-cycle op.
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'hAAAAAAAA, 32'h0, 32'h0, 0, 0);
        @(negedge CB);
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'hBBBBBBBB, 32'h0, 32'h0, 0, 0);
        @(negedge CB);
        chk("pre-flush valid", 32'(wbValid), 32'd1);
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'hCCCCCCCC, 32'h0, 32'h0, 0, 0);
        exeFlush = 1'b1;
        exeHold = 1'b1;
        @(negedge CB);
        chk("flush valid", 32'(wbValid), 32'd0);
        exeFlush = 1'b0;
        exeHold = 1'b0;
        exeValid = 1'b0;
        @(negedge CB);
        chk("flush drops ops", 32'(wbValid), 32'd0);

        // Reset mid-stream, with hold asserted.
        drive(OP_SRA, 5'd0, 5'd0, 6'd33, 32'h80000000, 32'h80000000, 32'h0, 1, 1);
        @(negedge CB);
        drive(OP_RLW, 5'd0, 5'd31, 6'd0, 32'h12345678, 32'h0, 32'h0, 1, 1);
        @(negedge CB);
        chk("pre-reset result", wbResult, 32'hFFFFFFFF);
        syncReset = 1'b1;
        exeHold = 1'b1;
        @(negedge CB);
        chk("mid reset valid",  32'(wbValid), 32'd0);
        chk("mid reset result", wbResult, 32'h0);
        chk("mid reset ca",     32'(wbCa), 32'd0);
        chk("mid reset caUpd",  32'(wbCaUpd), 32'd0);
        chk("mid reset cr0",    32'(wbCr0), 32'd0);
        chk("mid reset cr0Upd", 32'(wbCr0Upd), 32'd0);
        syncReset = 1'b0;
        exeHold = 1'b0;
        exeValid = 1'b0;
        @(negedge CB);
        chk("post reset valid", 32'(wbValid), 32'd0);
        @(negedge CB);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
